// File: rtl/scoreboard_mp_pkg.sv
// Shared definitions for the multi-port issue scoreboard.
// The data/payload part of a slot is sized by the instantiating module.
package scoreboard_mp_pkg;

    localparam int REG_ADDR_SIZE = 5;
    localparam int NR_ARCH_REGS  = 32;

    // Width-independent bookkeeping part of a scoreboard slot.
    typedef struct packed {
        logic                     occupied;
        logic                     done;
        logic                     ex;
        logic [REG_ADDR_SIZE-1:0] rd;
    } sb_mp_ctrl_t;

endpackage

// File: rtl/sb_youngest_match.sv
// Finds the youngest occupied slot whose destination matches rs.
// Slots are walked oldest-to-youngest from head, so the last hit wins.
module sb_youngest_match
    import scoreboard_mp_pkg::*;
#(
    parameter  int NR_ENTRIES = 8,
    localparam int IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic [NR_ENTRIES-1:0]                    occupied,
    input  logic [NR_ENTRIES-1:0][REG_ADDR_SIZE-1:0] rd,
    input  logic [IDX_W-1:0]                         head,
    input  logic [REG_ADDR_SIZE-1:0]                 rs,
    output logic                                     found,
    output logic [IDX_W-1:0]                         index
);

    logic [IDX_W-1:0] slot_idx;

    always_comb begin
        found    = 1'b0;
        index    = '0;
        slot_idx = '0;
        for (int a = 0; a < NR_ENTRIES; a++) begin
            slot_idx = head + IDX_W'(a);
            if (occupied[slot_idx] && (rd[slot_idx] == rs)) begin
                found = 1'b1;
                index = slot_idx;
            end
        end
    end

endmodule

// File: rtl/scoreboard_mp.sv
// Ring-buffer issue scoreboard: one alloc, NR_WB_PORTS writebacks and up to
// NR_COMMIT_PORTS in-order commits per cycle, with operand forwarding.
module scoreboard_mp
    import scoreboard_mp_pkg::*;
#(
    parameter  int NR_ENTRIES      = 8,
    parameter  int NR_WB_PORTS     = 4,
    parameter  int NR_COMMIT_PORTS = 2,
    parameter  int XLEN            = 64,
    parameter  int PAYLOAD_W       = 32,
    localparam int IDX_W           = $clog2(NR_ENTRIES)
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        flush_i,
    input  logic                                        alloc_valid_i,
    output logic                                        alloc_ready_o,
    input  logic [REG_ADDR_SIZE-1:0]                    alloc_rd_i,
    input  logic [PAYLOAD_W-1:0]                        alloc_payload_i,
    output logic [IDX_W-1:0]                            alloc_trans_id_o,
    input  logic [NR_WB_PORTS-1:0]                      wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][IDX_W-1:0]           wb_trans_id_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_data_i,
    input  logic [NR_WB_PORTS-1:0]                      wb_ex_i,
    output logic [NR_COMMIT_PORTS-1:0]                  commit_valid_o,
    output logic [NR_COMMIT_PORTS-1:0][REG_ADDR_SIZE-1:0] commit_rd_o,
    output logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]        commit_data_o,
    output logic [NR_COMMIT_PORTS-1:0]                  commit_ex_o,
    output logic [NR_COMMIT_PORTS-1:0][PAYLOAD_W-1:0]   commit_payload_o,
    input  logic [NR_COMMIT_PORTS-1:0]                  commit_ack_i,
    input  logic [REG_ADDR_SIZE-1:0]                    rs1_i,
    input  logic [REG_ADDR_SIZE-1:0]                    rs2_i,
    output logic                                        rs1_busy_o,
    output logic                                        rs2_busy_o,
    output logic                                        rs1_valid_o,
    output logic                                        rs2_valid_o,
    output logic [XLEN-1:0]                             rs1_o,
    output logic [XLEN-1:0]                             rs2_o,
    output logic [NR_ARCH_REGS-1:0]                     rd_clobber_o,
    output logic [IDX_W:0]                              count_o
);

    typedef struct packed {
        sb_mp_ctrl_t          ctrl;
        logic [XLEN-1:0]      data;
        logic [PAYLOAD_W-1:0] payload;
    } sb_mp_entry_t;

    sb_mp_entry_t     slot_reg [NR_ENTRIES];
    logic [IDX_W-1:0] head_reg;
    logic [IDX_W-1:0] tail_reg;
    logic [IDX_W:0]   count_reg;

    logic                                     alloc_fire;
    logic [NR_ENTRIES-1:0]                    occ_vec;
    logic [NR_ENTRIES-1:0][REG_ADDR_SIZE-1:0] rd_vec;
    logic [NR_ENTRIES-1:0]                    wb_hit;
    logic [NR_ENTRIES-1:0][XLEN-1:0]          wb_data_sel;
    logic [NR_ENTRIES-1:0]                    wb_ex_sel;
    logic [NR_ENTRIES-1:0]                    commit_clr;
    logic [NR_COMMIT_PORTS-1:0][IDX_W-1:0]    commit_idx;
    logic [NR_COMMIT_PORTS-1:0]               commit_valid;
    logic [NR_COMMIT_PORTS-1:0]               retire;
    logic [IDX_W:0]                           retire_cnt;
    logic                                     chain;
    logic                                     run;
    logic                                     rs1_found;
    logic                                     rs2_found;
    logic [IDX_W-1:0]                         rs1_idx;
    logic [IDX_W-1:0]                         rs2_idx;
    logic [NR_ARCH_REGS-1:0]                  clobber;

    assign alloc_ready_o    = (count_reg != (IDX_W+1)'(NR_ENTRIES));
    assign alloc_trans_id_o = tail_reg;
    assign alloc_fire       = alloc_valid_i && alloc_ready_o;
    assign count_o          = count_reg;

    generate
        for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_slot_view
            assign occ_vec[gi] = slot_reg[gi].ctrl.occupied;
            assign rd_vec[gi]  = slot_reg[gi].ctrl.rd;
        end
        for (genvar gi = 0; gi < NR_COMMIT_PORTS; gi++) begin : g_commit_port
            assign commit_idx[gi]       = head_reg + IDX_W'(gi);
            assign commit_rd_o[gi]      = slot_reg[commit_idx[gi]].ctrl.rd;
            assign commit_data_o[gi]    = slot_reg[commit_idx[gi]].data;
            assign commit_ex_o[gi]      = slot_reg[commit_idx[gi]].ctrl.ex;
            assign commit_payload_o[gi] = slot_reg[commit_idx[gi]].payload;
        end
    endgenerate

    // Writeback merge: ascending port order so the highest port wins.
    always_comb begin
        wb_hit      = '0;
        wb_data_sel = '0;
        wb_ex_sel   = '0;
        for (int s = 0; s < NR_ENTRIES; s++) begin
            for (int p = 0; p < NR_WB_PORTS; p++) begin
                if (wb_valid_i[p] && (wb_trans_id_i[p] == IDX_W'(s))) begin
                    wb_hit[s]      = occ_vec[s];
                    wb_data_sel[s] = wb_data_i[p];
                    wb_ex_sel[s]   = wb_ex_i[p];
                end
            end
        end
    end

    // Commit ports form a contiguous run from head; retirement stops at the first gap.
    always_comb begin
        commit_valid = '0;
        retire       = '0;
        retire_cnt   = '0;
        commit_clr   = '0;
        chain        = 1'b1;
        run          = 1'b1;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            commit_valid[k] = chain && slot_reg[commit_idx[k]].ctrl.occupied
                                    && slot_reg[commit_idx[k]].ctrl.done;
            chain           = commit_valid[k];
            retire[k]       = run && commit_ack_i[k] && commit_valid[k];
            run             = retire[k];
            if (retire[k]) begin
                retire_cnt                = retire_cnt + 1'b1;
                commit_clr[commit_idx[k]] = 1'b1;
            end
        end
    end

    assign commit_valid_o = commit_valid;

    sb_youngest_match #(.NR_ENTRIES(NR_ENTRIES)) u_match_rs1 (
        .occupied (occ_vec),
        .rd       (rd_vec),
        .head     (head_reg),
        .rs       (rs1_i),
        .found    (rs1_found),
        .index    (rs1_idx)
    );

    sb_youngest_match #(.NR_ENTRIES(NR_ENTRIES)) u_match_rs2 (
        .occupied (occ_vec),
        .rd       (rd_vec),
        .head     (head_reg),
        .rs       (rs2_i),
        .found    (rs2_found),
        .index    (rs2_idx)
    );

    // x0 is never tracked even if an entry names it as destination.
    assign rs1_busy_o  = rs1_found && (rs1_i != '0);
    assign rs2_busy_o  = rs2_found && (rs2_i != '0);
    assign rs1_valid_o = rs1_busy_o && (slot_reg[rs1_idx].ctrl.done || wb_hit[rs1_idx]);
    assign rs2_valid_o = rs2_busy_o && (slot_reg[rs2_idx].ctrl.done || wb_hit[rs2_idx]);
    assign rs1_o = !rs1_busy_o      ? '0 :
                   wb_hit[rs1_idx]  ? wb_data_sel[rs1_idx] : slot_reg[rs1_idx].data;
    assign rs2_o = !rs2_busy_o      ? '0 :
                   wb_hit[rs2_idx]  ? wb_data_sel[rs2_idx] : slot_reg[rs2_idx].data;

    always_comb begin
        clobber = '0;
        for (int s = 0; s < NR_ENTRIES; s++) begin
            if (occ_vec[s] && (rd_vec[s] != '0)) begin
                clobber[rd_vec[s]] = 1'b1;
            end
        end
    end

    assign rd_clobber_o = clobber;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int s = 0; s < NR_ENTRIES; s++) begin
                slot_reg[s] <= '0;
            end
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            head_reg  <= head_reg + retire_cnt[IDX_W-1:0];
            count_reg <= count_reg + (IDX_W+1)'(alloc_fire) - retire_cnt;
            for (int s = 0; s < NR_ENTRIES; s++) begin
                if (commit_clr[s]) begin
                    slot_reg[s] <= '0;
                end else if (alloc_fire && (tail_reg == IDX_W'(s))) begin
                    slot_reg[s].ctrl.occupied <= 1'b1;
                    slot_reg[s].ctrl.done     <= 1'b0;
                    slot_reg[s].ctrl.ex       <= 1'b0;
                    slot_reg[s].ctrl.rd       <= alloc_rd_i;
                    slot_reg[s].data          <= '0;
                    slot_reg[s].payload       <= alloc_payload_i;
                end else if (wb_hit[s]) begin
                    slot_reg[s].ctrl.done <= 1'b1;
                    slot_reg[s].ctrl.ex   <= wb_ex_sel[s];
                    slot_reg[s].data      <= wb_data_sel[s];
                end
            end
        end
    end

endmodule
